// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial subtractor: diff = a - b - bin (modulo 2^WIDTH), LSB first,
//   one bit per clock through a single full-subtractor cell with a registered
//   borrow. Handshake is start / busy / done.
//
//   Optional feature macro: SERIAL_SUB_OVF_EN adds the signed-overflow
//   output ovf_o and the sign-capture registers behind it.
//
// Ports
//   clk      in   1      rising-edge clock
//   rst_n    in   1      asynchronous, active-low reset
//   start_i  in   1      request; sampled only in IDLE
//   a_i      in   WIDTH  minuend, captured on the accepted start edge
//   b_i      in   WIDTH  subtrahend, captured on the accepted start edge
//   bin_i    in   1      borrow-in, captured on the accepted start edge
//   busy_o   out  1      high while bits are being processed (SHIFT)
//   done_o   out  1      one-cycle completion pulse
//   diff_o   out  WIDTH  last completed result
//   bout_o   out  1      final borrow-out, held with diff_o
//   ovf_o    out  1      signed overflow (only with SERIAL_SUB_OVF_EN)
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start_i; operands captured on the accepting edge
// SHIFT | one result bit per cycle, WIDTH cycles, busy_o high
// DONE  | done_o high for this single cycle, then back to IDLE

module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             bin_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] diff_o,
  output logic             bout_o
`ifdef SERIAL_SUB_OVF_EN
 ,output logic             ovf_o
`endif
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_sr_q;
  logic [WIDTH-1:0] b_sr_q;
  logic [WIDTH-1:0] work_q;
  logic [CNT_W-1:0] cnt_q;
  logic             br_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] diff_q;
  logic             bout_q;

  logic             diff_bit;
  logic             br_d;
  logic [WIDTH-1:0] work_d;

  // Full-subtractor cell on the current LSBs; work_d shifts the new bit in
  // at the MSB so that after WIDTH steps bit 0 of the result sits at bit 0.
  always_comb begin
    diff_bit = a_sr_q[0] ^ b_sr_q[0] ^ br_q;
    br_d     = (~a_sr_q[0] & b_sr_q[0]) | (~(a_sr_q[0] ^ b_sr_q[0]) & br_q);
    work_d   = (work_q >> 1) | (WIDTH'(diff_bit) << (WIDTH - 1));
  end

`ifdef SERIAL_SUB_OVF_EN
  // a_sr/b_sr are consumed by the shift, so the operand signs are kept apart.
  logic sa_q;
  logic sb_q;
  logic ovf_q;
  logic ovf_d;

  always_comb begin
    ovf_d = (sa_q ^ sb_q) & (work_d[WIDTH-1] ^ sa_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa_q  <= 1'b0;
      sb_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      if (state_q == S_IDLE && start_i) begin
        sa_q <= a_i[WIDTH-1];
        sb_q <= b_i[WIDTH-1];
      end
      if (state_q == S_SHIFT && cnt_q == CNT_LAST) begin
        ovf_q <= ovf_d;
      end
    end
  end

  assign ovf_o = ovf_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      work_q  <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start_i) begin
            a_sr_q  <= a_i;
            b_sr_q  <= b_i;
            br_q    <= bin_i;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          a_sr_q <= a_sr_q >> 1;
          b_sr_q <= b_sr_q >> 1;
          work_q <= work_d;
          br_q   <= br_d;
          cnt_q  <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            diff_q  <= work_d;
            bout_q  <= br_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign diff_o = diff_q;
  assign bout_o = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor: an 8-bit instance for the main
// handshake/arithmetic cases and a 1-bit instance for the full-subtractor
// truth table. Overflow cases are checked only when SERIAL_SUB_OVF_EN is set.

module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       bin;
  logic       busy;
  logic       done;
  logic [7:0] diff;
  logic       bout;

  logic       start1;
  logic [0:0] a1;
  logic [0:0] b1;
  logic       bin1;
  logic       busy1;
  logic       done1;
  logic [0:0] diff1;
  logic       bout1;

`ifdef SERIAL_SUB_OVF_EN
  logic       ovf;
  logic       ovf1;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) u_dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (start),
    .a_i     (a),
    .b_i     (b),
    .bin_i   (bin),
    .busy_o  (busy),
    .done_o  (done),
    .diff_o  (diff),
    .bout_o  (bout)
`ifdef SERIAL_SUB_OVF_EN
   ,.ovf_o   (ovf)
`endif
  );

  serial_subtractor #(.WIDTH(1)) u_dut1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (start1),
    .a_i     (a1),
    .b_i     (b1),
    .bin_i   (bin1),
    .busy_o  (busy1),
    .done_o  (done1),
    .diff_o  (diff1),
    .bout_o  (bout1)
`ifdef SERIAL_SUB_OVF_EN
   ,.ovf_o   (ovf1)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at #1 after an edge with the 8-bit DUT idle; returns at #1 after
  // the edge that takes it from DONE back to IDLE.
  task automatic run_op(input string tag, input logic [7:0] ta, input logic [7:0] tb_v,
                        input logic tbin, input logic [7:0] ed, input logic eb, input logic eo);
    int         n;
    int         busyc;
    logic [7:0] prev_diff;
    logic       prev_bout;
    logic       stable;
    prev_diff = diff;
    prev_bout = bout;
    stable    = 1'b1;
    a = ta; b = tb_v; bin = tbin; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = ~ta; b = 8'h5A; bin = ~tbin;
    n = 0;
    busyc = 0;
    while (done !== 1'b1 && n < 40) begin
      if (busy === 1'b1) busyc++;
      if (diff !== prev_diff || bout !== prev_bout) stable = 1'b0;
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_latency"}, n, 8);
    check({tag, "_busy_cycles"}, busyc, 8);
    check({tag, "_hold"}, stable, 1);
    check({tag, "_busy_at_done"}, busy, 0);
    check({tag, "_diff"}, diff, ed);
    check({tag, "_bout"}, bout, eb);
`ifdef SERIAL_SUB_OVF_EN
    check({tag, "_ovf"}, ovf, eo);
`else
    if (eo === 1'bx) check({tag, "_eo"}, eo, 0);
`endif
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, done, 0);
  endtask

  initial begin
    logic [7:0] ea;
    logic [7:0] eb8;
    logic [7:0] ed;
    logic [7:0] tt_d;
    logic [7:0] tt_b;
    logic [7:0] tt_o;
    logic [2:0] v;
    int         dones;

    rst_n = 1'b0;
    start = 1'b0; a = '0; b = '0; bin = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; bin1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_diff", diff, 0);
    check("rst_bout", bout, 0);
    check("rst_diff1", diff1, 0);
`ifdef SERIAL_SUB_OVF_EN
    check("rst_ovf", ovf, 0);
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("t1",   8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0);
    run_op("t2a",  8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0);
    run_op("t2b",  8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0);
    run_op("ovf1", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
    run_op("ovf2", 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1);
    run_op("ovf3", 8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0);
    run_op("t_ff", 8'hFF, 8'h00, 1'b1, 8'hFE, 1'b0, 1'b0);

    // start held high with operands changing every cycle: accepts at
    // edges 0, 10, 20 and done seen after edges 8, 18, 28.
    dones = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      a = 8'(cyc * 7 + 3);
      b = 8'(cyc * 13 + 1);
      bin = 1'b0;
      start = 1'b1;
      @(posedge clk); #1;
      if (done === 1'b1) begin
        dones++;
        ea  = 8'((cyc - 8) * 7 + 3);
        eb8 = 8'((cyc - 8) * 13 + 1);
        ed  = ea - eb8;
        check("t3_phase", cyc % 10, 8);
        check("t3_busy", busy, 0);
        check("t3_diff", diff, ed);
        check("t3_bout", bout, (ea < eb8) ? 1 : 0);
      end
    end
    start = 1'b0;
    check("t3_done_count", dones, 3);

    // Reset asserted in the 4th SHIFT cycle.
    a = 8'h55; b = 8'h11; bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("t4_busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    check("t4_busy", busy, 0);
    check("t4_diff", diff, 0);
    check("t4_bout", bout, 0);
    check("t4_done", done, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) dones++;
    end
    check("t4_no_done", dones, 0);
    run_op("t4_after", 8'h55, 8'h11, 1'b0, 8'h44, 1'b0, 1'b0);

    // WIDTH=1 truth table, index {a,b,bin}.
    tt_d = 8'b1001_0110;
    tt_b = 8'b1000_1110;
    tt_o = 8'b0010_0100;
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      a1 = v[2]; b1 = v[1]; bin1 = v[0]; start1 = 1'b1;
      @(posedge clk); #1;
      start1 = 1'b0;
      check("w1_busy", busy1, 1);
      check("w1_done_early", done1, 0);
      @(posedge clk); #1;
      check("w1_done", done1, 1);
      check("w1_diff", diff1, tt_d[i]);
      check("w1_bout", bout1, tt_b[i]);
`ifdef SERIAL_SUB_OVF_EN
      check("w1_ovf", ovf1, tt_o[i]);
`endif
      @(posedge clk); #1;
      check("w1_done_pulse", done1, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
